// File: rtl/elastic_fifo.sv
`timescale 1ns/1ps
// elastic_fifo: valid/ready token buffer built as a circular buffer of
// NUM_SLOTS entries. The head and tail pointers wrap at NUM_SLOTS-1, so the
// depth does not have to be a power of two. A full flag tells a completely
// full buffer apart from an empty one when head == tail.
// Optional feature: define ELASTIC_FIFO_BYPASS_EN to add a zero-latency
// pass-through path. That path is used only while the buffer is empty.
module elastic_fifo #(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic                 r_full;

    logic                 w_empty;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic [PTR_W-1:0]     w_head_nxt;
    logic [PTR_W-1:0]     w_tail_nxt;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        if (p == LAST_SLOT)
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Output channel and handshake decode. ins_ready depends only on r_full,
    // so there is never a combinational path from outs_ready to ins_ready.
    always_comb begin
        w_empty    = (r_head == r_tail) && !r_full;
        ins_ready  = !r_full;
`ifdef ELASTIC_FIFO_BYPASS_EN
        // A token that passes straight through while the buffer is empty is
        // never written to memory.
        w_bypass   = w_empty && ins_valid && outs_ready;
        outs       = w_empty ? ins : r_mem[r_head];
        outs_valid = w_empty ? ins_valid : 1'b1;
`else
        w_bypass   = 1'b0;
        outs       = r_mem[r_head];
        outs_valid = !w_empty;
`endif
        w_push     = ins_valid && ins_ready && !w_bypass;
        w_pop      = !w_empty && outs_ready;
        w_head_nxt = f_next(r_head);
        w_tail_nxt = f_next(r_tail);
    end

    // Payload storage. Reset clears every entry, so outs reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_tail] <= ins;
        end
    end

    // Pointer and full-flag update. A simultaneous push and pop leaves r_full unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push)
                r_tail <= w_tail_nxt;
            if (w_pop)
                r_head <= w_head_nxt;
            if (w_push && !w_pop)
                r_full <= (w_tail_nxt == r_head);
            else if (w_pop && !w_push)
                r_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elastic_fifo.sv
`timescale 1ns/1ps
// Self-checking bench for elastic_fifo (NUM_SLOTS=4, DATA_TYPE=8).
// The reference model is a token queue. It follows the bypass macro when
// that macro is defined.
module tb_elastic_fifo;

    localparam int DEPTH = 4;
`ifdef ELASTIC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       tb_rst = 1'b0;
    logic [7:0] tb_ins = 8'h00;
    logic       tb_ins_valid = 1'b0;
    logic       tb_ins_ready;
    logic [7:0] tb_outs;
    logic       tb_outs_valid;
    logic       tb_outs_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];

    always #5 clk = ~clk;

    elastic_fifo #(.NUM_SLOTS(DEPTH), .DATA_TYPE(8)) dut (
        .clk        (clk),
        .rst        (tb_rst),
        .ins        (tb_ins),
        .ins_valid  (tb_ins_valid),
        .ins_ready  (tb_ins_ready),
        .outs       (tb_outs),
        .outs_valid (tb_outs_valid),
        .outs_ready (tb_outs_ready)
    );

    // Reference model: expected outputs for the current inputs.
    function automatic logic m_valid();
        return (q.size() > 0) || (BYP && tb_ins_valid);
    endfunction

    function automatic logic [7:0] m_outs();
        return (q.size() > 0) ? q[0] : tb_ins;
    endfunction

    function automatic logic m_ready();
        return q.size() < DEPTH;
    endfunction

    // Reference model: update at a clock edge.
    task automatic m_commit();
        bit take, pop, push;
        if (tb_rst) begin
            q.delete();
        end else begin
            take = BYP && (q.size() == 0) && tb_ins_valid && tb_outs_ready;
            pop  = (q.size() > 0) && tb_outs_ready;
            push = tb_ins_valid && (q.size() < DEPTH);
            if (!take) begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(tb_ins);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        tb_ins_valid  = v;
        tb_ins        = d;
        tb_outs_ready = r;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b0);
        tb_rst = 1'b1;
        tick();
        tick();
        tb_rst = 1'b0;
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL reset_outs_valid got %0b exp 0", tb_outs_valid); end
        checks++; if (tb_ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ins_ready got %0b exp 1", tb_ins_ready); end
        checks++; if (tb_outs !== 8'h00) begin errors++; $display("FAIL reset_outs got %h exp 00", tb_outs); end
        tick();
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] exp_seq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0);
            @(negedge clk);
            checks++; if (tb_ins_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %0b exp 1", i, tb_ins_ready); end
            tick();
        end
        // The buffer is full. 0x55 is offered while 0x11 is popped in the same cycle.
        drive(1'b1, 8'h55, 1'b1);
        @(negedge clk);
        checks++; if (tb_ins_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", tb_ins_ready); end
        checks++; if (tb_outs_valid !== 1'b1 || tb_outs !== 8'h11) begin errors++; $display("FAIL full_head got %0b/%h exp 1/11", tb_outs_valid, tb_outs); end
        tick();
        @(negedge clk);
        checks++; if (tb_ins_ready !== 1'b1) begin errors++; $display("FAIL freed_ready got %0b exp 1", tb_ins_ready); end
        checks++; if (tb_outs !== 8'h22) begin errors++; $display("FAIL second_out got %h exp 22", tb_outs); end
        tick();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            checks++; if (tb_outs_valid !== 1'b1 || tb_outs !== exp_seq[i]) begin errors++; $display("FAIL drain[%0d] got %0b/%h exp 1/%h", i, tb_outs_valid, tb_outs, exp_seq[i]); end
            tick();
        end
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %0b exp 0", tb_outs_valid); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL model_empty got %0d exp 0", q.size()); end
        tick();
    endtask

    task automatic test_stream();
        logic [7:0] got[$];
        for (int c = 0; c < 20; c++) begin
            if (c < 16) drive(1'b1, 8'(c), 1'b1);
            else        drive(1'b0, 8'h00, 1'b1);
            @(negedge clk);
            checks++; if (tb_ins_ready !== 1'b1) begin errors++; $display("FAIL stream_stall[%0d] got %0b exp 1", c, tb_ins_ready); end
            checks++; if (tb_outs_valid !== m_valid()) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp %0b", c, tb_outs_valid, m_valid()); end
            if (tb_outs_valid && tb_outs_ready) got.push_back(tb_outs);
            tick();
        end
        checks++; if (got.size() != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL stream_order[%0d] got %h exp %h", i, got[i], 8'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hAA, 1'b0); tick();
        drive(1'b1, 8'hBB, 1'b0); tick();
        // A handshake offered together with reset has to be dropped.
        drive(1'b1, 8'hCC, 1'b1);
        tb_rst = 1'b1;
        tick();
        tb_rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", tb_outs_valid); end
        checks++; if (tb_outs !== 8'h00) begin errors++; $display("FAIL rstmid_outs got %h exp 00", tb_outs); end
        checks++; if (tb_ins_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b exp 1", tb_ins_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost[%0d] got %0b/%h exp 0", c, tb_outs_valid, tb_outs); end
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 8'hA5, 1'b1);
        @(negedge clk);
`ifdef ELASTIC_FIFO_BYPASS_EN
        checks++; if (tb_outs_valid !== 1'b1 || tb_outs !== 8'hA5) begin errors++; $display("FAIL bypass_same got %0b/%h exp 1/a5", tb_outs_valid, tb_outs); end
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL bypass_empty got %0b exp 0", tb_outs_valid); end
`else
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same got %0b exp 0", tb_outs_valid); end
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b1 || tb_outs !== 8'hA5) begin errors++; $display("FAIL nobypass_next got %0b/%h exp 1/a5", tb_outs_valid, tb_outs); end
`endif
        tick();
        @(negedge clk);
        checks++; if (tb_outs_valid !== 1'b0) begin errors++; $display("FAIL bypass_after got %0b exp 0", tb_outs_valid); end
        tick();
    endtask

    task automatic test_random();
        int sent = 0;
        int recv = 0;
        logic [7:0] exp_o;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0 || c > 380));
            if (c >= 370) tb_ins_valid = 1'b0;
            @(negedge clk);
            checks++; if (tb_ins_ready !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d] got %0b exp %0b", c, tb_ins_ready, m_ready()); end
            checks++; if (tb_outs_valid !== m_valid()) begin errors++; $display("FAIL rand_valid[%0d] got %0b exp %0b", c, tb_outs_valid, m_valid()); end
            if (m_valid()) begin
                exp_o = m_outs();
                checks++; if (tb_outs !== exp_o) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", c, tb_outs, exp_o); end
            end
            if (tb_ins_valid && m_ready()) sent++;
            if (m_valid() && tb_outs_ready) recv++;
            tick();
        end
        checks++; if (sent != recv || q.size() != 0) begin errors++; $display("FAIL rand_conservation sent %0d recv %0d left %0d exp equal/0", sent, recv, q.size()); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
